// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WB and drives datapath controls.
// Memory accesses wait on mem_ready; a watchdog aborts stalled accesses and sets a sticky mem_err.
module mc_control_fsm #(
  parameter int OPCODE_W       = 6,
  parameter int ALUOP_W        = 2,
  parameter bit ENABLE_BNE     = 1'b1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic                branch,
  output logic                branch_ne,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                illegal_op,
  output logic                mem_err,
  output logic [3:0]          state
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt;
  logic             is_bne_q;
  logic             mem_err_q;
  logic             timeout;
  logic             mem_req_c, mem_we_c, ir_write_c, pc_write_c;
  logic             branch_c, branch_ne_c, reg_write_c, illegal_c;

  always_comb begin
    state_d     = state_q;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    branch_c    = 1'b0;
    branch_ne_c = 1'b0;
    reg_write_c = 1'b0;
    illegal_c   = 1'b0;
    iord        = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = '0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        alu_src_b  = 2'b01;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_BNE: begin
            if (ENABLE_BNE) state_d = S_BRANCH;
            else begin
              state_d   = S_FETCH;
              illegal_c = 1'b1;
            end
          end
          default: begin
            state_d   = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_c = 1'b1;
        mem_to_reg  = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_W'(2'b10);
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        reg_dst     = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_op      = ALUOP_W'(2'b01);
        pc_src      = 2'b01;
        branch_c    = ~is_bne_q;
        branch_ne_c = is_bne_q;
        state_d     = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_write_c = 1'b1;
        pc_src     = 2'b10;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Abort only when the counter already holds the limit; a same-cycle mem_ready completes normally.
    timeout = (TIMEOUT_CYCLES > 0) && mem_req_c && !mem_ready && (wait_cnt == CNT_MAX);
    if (timeout) state_d = S_FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_cnt  <= '0;
      is_bne_q  <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) is_bne_q <= (opcode == OP_BNE);
      if (timeout) mem_err_q <= 1'b1;
      if (state_d != state_q || mem_ready || timeout) wait_cnt <= '0;
      else if (mem_req_c && wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Enables are held low combinationally while reset is asserted, so an aborted access cannot glitch.
  assign mem_req    = mem_req_c   & rst_n;
  assign mem_we     = mem_we_c    & rst_n;
  assign ir_write   = ir_write_c  & rst_n;
  assign pc_write   = pc_write_c  & rst_n;
  assign branch     = branch_c    & rst_n;
  assign branch_ne  = branch_ne_c & rst_n;
  assign reg_write  = reg_write_c & rst_n;
  assign illegal_op = illegal_c   & rst_n;
  assign mem_err    = mem_err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: dut_a has bne enabled and a 4-cycle watchdog, dut_b has bne disabled.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_ready;
  logic [5:0] opcode;

  logic a_mem_req, a_mem_we, a_iord, a_ir_write, a_pc_write, a_branch, a_branch_ne;
  logic a_alu_src_a, a_reg_write, a_reg_dst, a_mem_to_reg, a_illegal_op, a_mem_err;
  logic [1:0] a_pc_src, a_alu_src_b, a_alu_op;
  logic [3:0] a_state;

  logic b_mem_req, b_mem_we, b_iord, b_ir_write, b_pc_write, b_branch, b_branch_ne;
  logic b_alu_src_a, b_reg_write, b_reg_dst, b_mem_to_reg, b_illegal_op, b_mem_err;
  logic [1:0] b_pc_src, b_alu_src_b, b_alu_op;
  logic [3:0] b_state;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] lw_st  [10] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
  logic       lw_rdy [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  mc_control_fsm #(.ENABLE_BNE(1'b1), .TIMEOUT_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .iord(a_iord), .ir_write(a_ir_write),
    .pc_write(a_pc_write), .branch(a_branch), .branch_ne(a_branch_ne), .pc_src(a_pc_src),
    .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .alu_op(a_alu_op),
    .reg_write(a_reg_write), .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg),
    .illegal_op(a_illegal_op), .mem_err(a_mem_err), .state(a_state)
  );

  mc_control_fsm #(.ENABLE_BNE(1'b0), .TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .iord(b_iord), .ir_write(b_ir_write),
    .pc_write(b_pc_write), .branch(b_branch), .branch_ne(b_branch_ne), .pc_src(b_pc_src),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op),
    .reg_write(b_reg_write), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
    .illegal_op(b_illegal_op), .mem_err(b_mem_err), .state(b_state)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    opcode    = 6'h00;
    mem_ready = 1'b0;
    #1;
    chk("rst_state",   a_state,     4'd0);
    chk("rst_mem_req", a_mem_req,   1'b0);
    chk("rst_irw",     a_ir_write,  1'b0);
    chk("rst_pcw",     a_pc_write,  1'b0);
    chk("rst_srcb",    a_alu_src_b, 2'b01);
    chk("rst_err",     a_mem_err,   1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // R-type with zero-wait memory: 0,1,6,7 then back to 0
    opcode = 6'h00; mem_ready = 1'b1; #1;
    chk("r_f_state", a_state,    4'd0);
    chk("r_f_irw",   a_ir_write, 1'b1);
    chk("r_f_pcw",   a_pc_write, 1'b1);
    chk("r_f_req",   a_mem_req,  1'b1);
    tick;
    chk("r_d_state", a_state,     4'd1);
    chk("r_d_srcb",  a_alu_src_b, 2'b11);
    chk("r_d_rw",    a_reg_write, 1'b0);
    tick;
    chk("r_e_state", a_state,     4'd6);
    chk("r_e_aluop", a_alu_op,    2'b10);
    chk("r_e_srca",  a_alu_src_a, 1'b1);
    chk("r_e_rw",    a_reg_write, 1'b0);
    tick;
    chk("r_w_state", a_state,     4'd7);
    chk("r_w_rw",    a_reg_write, 1'b1);
    chk("r_w_dst",   a_reg_dst,   1'b1);
    tick;
    chk("r_done",    a_state,     4'd0);

    // lw: 3 FETCH waits, 2 MEMRD waits -> 10 cycles, single ir_write pulse
    opcode = 6'h23;
    for (int i = 0; i < 10; i++) begin
      mem_ready = lw_rdy[i];
      #1;
      chk("lw_state", a_state,    lw_st[i]);
      chk("lw_irw",   a_ir_write, (i == 3));
      if (i == 6) begin
        chk("lw_rd_req",  a_mem_req, 1'b1);
        chk("lw_rd_iord", a_iord,    1'b1);
      end
      if (i == 9) begin
        chk("lw_wb_m2r", a_mem_to_reg, 1'b1);
        chk("lw_wb_rw",  a_reg_write,  1'b1);
        chk("lw_wb_dst", a_reg_dst,    1'b0);
      end
      tick;
    end
    chk("lw_done", a_state,   4'd0);
    chk("lw_err",  a_mem_err, 1'b0);

    // bne: legal on dut_a, illegal on dut_b
    opcode = 6'h05; mem_ready = 1'b1; #1;
    chk("bne_b_f", b_state, 4'd0);
    tick;
    chk("bne_a_ill", a_illegal_op, 1'b0);
    chk("bne_b_ill", b_illegal_op, 1'b1);
    chk("bne_b_pcw", b_pc_write,   1'b0);
    chk("bne_b_rw",  b_reg_write,  1'b0);
    tick;
    chk("bne_a_state", a_state,     4'd8);
    chk("bne_a_bne",   a_branch_ne, 1'b1);
    chk("bne_a_beq",   a_branch,    1'b0);
    chk("bne_a_pcsrc", a_pc_src,    2'b01);
    chk("bne_a_aluop", a_alu_op,    2'b01);
    chk("bne_b_state", b_state,     4'd0);
    chk("bne_b_ill2",  b_illegal_op, 1'b0);
    opcode = 6'h04; #1;
    chk("bne_late_op", a_branch_ne, 1'b1);
    chk("bne_late_eq", a_branch,    1'b0);
    tick;
    chk("bne_done", a_state, 4'd0);

    // beq
    opcode = 6'h04;
    tick;
    tick;
    chk("beq_state", a_state,     4'd8);
    chk("beq_beq",   a_branch,    1'b1);
    chk("beq_bne",   a_branch_ne, 1'b0);
    tick;
    chk("beq_done",  a_state,     4'd0);

    // j: 3 cycles
    opcode = 6'h02;
    tick;
    chk("j_d_state", a_state,    4'd1);
    tick;
    chk("j_state",   a_state,    4'd11);
    chk("j_pcw",     a_pc_write, 1'b1);
    chk("j_pcsrc",   a_pc_src,   2'b10);
    tick;
    chk("j_done",    a_state,    4'd0);

    // sw with memory stalled in MEMWR: watchdog aborts
    opcode = 6'h2B; mem_ready = 1'b1;
    tick;
    tick;
    chk("sw_ma_state", a_state, 4'd2);
    tick;
    mem_ready = 1'b0; #1;
    chk("sw_wr_state", a_state,  4'd5);
    chk("sw_wr_req",   a_mem_req, 1'b1);
    chk("sw_wr_we",    a_mem_we,  1'b1);
    chk("sw_wr_iord",  a_iord,    1'b1);
    repeat (4) tick;
    chk("sw_wait_state", a_state,   4'd5);
    chk("sw_wait_err",   a_mem_err, 1'b0);
    tick;
    chk("sw_to_state", a_state,    4'd0);
    chk("sw_to_err",   a_mem_err,  1'b1);
    chk("sw_to_irw",   a_ir_write, 1'b0);

    // mem_err is sticky through a later instruction
    opcode = 6'h00; mem_ready = 1'b1;
    repeat (4) tick;
    chk("sticky_state", a_state,   4'd0);
    chk("sticky_err",   a_mem_err, 1'b1);

    // asynchronous reset in the middle of a stalled store
    opcode = 6'h2B;
    tick;
    tick;
    tick;
    mem_ready = 1'b0;
    tick;
    chk("mid_pre_state", a_state, 4'd5);
    rst_n = 1'b0; #1;
    chk("mid_rst_state", a_state,   4'd0);
    chk("mid_rst_req",   a_mem_req, 1'b0);
    chk("mid_rst_we",    a_mem_we,  1'b0);
    chk("mid_rst_err",   a_mem_err, 1'b0);
    tick;
    rst_n = 1'b1;

    // mem_ready in the very cycle the wait counter hits the limit: normal completion
    mem_ready = 1'b1;
    tick;
    tick;
    tick;
    mem_ready = 1'b0;
    repeat (4) tick;
    chk("lim_state", a_state, 4'd5);
    mem_ready = 1'b1; #1;
    chk("lim_err0",  a_mem_err, 1'b0);
    tick;
    chk("lim_done",  a_state,   4'd0);
    chk("lim_err1",  a_mem_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
